// File: rtl/clk_div_prog.sv
// Programmable integer clock divider. The divisor can be reloaded at run time,
// and a new divisor takes effect only at a period boundary so clk_out never glitches.
module clk_div_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_cur,
   output logic             busy,
   output logic             div_err
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] n_cur;
   logic [WIDTH-1:0] p_div;
   logic [WIDTH-1:0] n_last;
   logic [WIDTH:0]   half;
   logic             wrap;
   logic             load_ok;
   logic             load_bad;

   // half is one bit wider than the divisor so N = 2^WIDTH-1 rounds up without overflow
   assign n_last   = n_cur - ONE;
   assign half     = ({1'b0, n_cur} + {1'b0, ONE}) >> 1;
   assign wrap     = (cnt == n_last);
   assign load_ok  = div_load && (div_val > ONE);
   assign load_bad = div_load && !(div_val > ONE);
   assign div_cur  = n_cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         n_cur   <= DEF_DIV;
         p_div   <= DEF_DIV;
         busy    <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
         div_err <= 1'b0;
      end else begin
         div_err <= load_bad;
         if (en) begin
            clk_out <= ({1'b0, cnt} < half);
            tick    <= wrap;
            cnt     <= wrap ? '0 : cnt + ONE;
            if (wrap && busy) begin
               n_cur <= p_div;
               busy  <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
            // while stopped there is no period to protect, so apply immediately
            if (busy) begin
               n_cur   <= p_div;
               busy    <= 1'b0;
               cnt     <= '0;
               clk_out <= 1'b0;
            end
         end
         // placed after the apply so a simultaneous load becomes the next pending value
         if (load_ok) begin
            p_div <= div_val;
            busy  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed and randomized bench for clk_div_prog, checked cycle by cycle against
// a period-position reference model.
module tb_clk_div_prog;

   localparam int WIDTH = 8;
   localparam int DEF   = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic [WIDTH-1:0] div_val = '0;
   logic             div_load = 1'b0;
   logic             clk_out;
   logic             tick;
   logic [WIDTH-1:0] div_cur;
   logic             busy;
   logic             div_err;

   int vectors = 0;
   int errors  = 0;

   // reference model: position within the current period, divisor, pending divisor (0 = none)
   int m_pos  = 0;
   int m_n    = DEF;
   int m_pend = 0;
   int e_clk  = 0;
   int e_tick = 0;
   int e_err  = 0;

   clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .clk_out  (clk_out),
      .tick     (tick),
      .div_cur  (div_cur),
      .busy     (busy),
      .div_err  (div_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_pos = 0; m_n = DEF; m_pend = 0;
         e_clk = 0; e_tick = 0; e_err = 0;
      end else begin
         e_err = (div_load && div_val < 2) ? 1 : 0;
         if (en) begin
            e_clk  = (m_pos < (m_n + 1) / 2) ? 1 : 0;
            e_tick = (m_pos == m_n - 1) ? 1 : 0;
            if (m_pos == m_n - 1) begin
               m_pos = 0;
               if (m_pend != 0) begin
                  m_n = m_pend; m_pend = 0;
               end
            end else begin
               m_pos++;
            end
         end else begin
            e_tick = 0;
            if (m_pend != 0) begin
               m_n = m_pend; m_pend = 0; m_pos = 0; e_clk = 0;
            end
         end
         if (div_load && div_val >= 2) m_pend = int'(div_val);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("clk_out", int'(clk_out), e_clk);
      check("tick",    int'(tick),    e_tick);
      check("div_cur", int'(div_cur), m_n);
      check("busy",    int'(busy),    (m_pend != 0) ? 1 : 0);
      check("div_err", int'(div_err), e_err);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic load_step(input int val);
      div_val  = WIDTH'(val);
      div_load = 1'b1;
      step();
      div_load = 1'b0;
   endtask

   // advance until the model sits at the given period position (bounded)
   task automatic wait_pos(input int pos);
      int guard = 0;
      while (m_pos != pos && guard < 600) begin
         step();
         guard++;
      end
      check("wait_pos_timeout", (m_pos == pos) ? 1 : 0, 1);
   endtask

   initial begin
      int highs;
      int lows;
      int guard;

      // defaults: two reset cycles, then free running divide-by-4
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      en  = 1'b1;
      run(12);

      // load 5 while cnt == 1; current 4-cycle period finishes first
      wait_pos(1);
      load_step(5);
      run(15);

      // rejected loads leave everything alone
      load_step(1);
      run(3);
      load_step(0);
      run(6);

      // hold en low for three cycles in the high phase
      wait_pos(1);
      en = 1'b0;
      run(3);
      en = 1'b1;
      run(8);

      // load while stopped: applied on the next edge
      en = 1'b0;
      load_step(6);
      run(1);
      check("div_cur_6", int'(div_cur), 6);
      check("clk_out_stop", int'(clk_out), 0);
      en = 1'b1;
      run(14);

      // widest divisor: 128 high, 127 low
      load_step(255);
      guard = 0;
      while (m_n != 255 && guard < 300) begin
         step();
         guard++;
      end
      check("apply_255_timeout", m_n, 255);
      highs = 0;
      lows  = 0;
      for (int i = 0; i < 255; i++) begin
         step();
         if (clk_out) highs++;
         else lows++;
      end
      check("high_255", highs, 128);
      check("low_255", lows, 127);

      // back-to-back loads: only the second one lands, at the wrap
      load_step(2);
      load_step(3);
      guard = 0;
      while (m_pend != 0 && guard < 300) begin
         step();
         guard++;
      end
      check("apply_3_timeout", guard < 300 ? 1 : 0, 1);
      check("div_cur_3", int'(div_cur), 3);
      run(9);

      // randomized mix of enable, loads and occasional reset
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 99) < 2);
         en       = ($urandom_range(0, 9) < 8);
         div_load = ($urandom_range(0, 9) == 0);
         div_val  = WIDTH'($urandom_range(0, 12));
         step();
      end
      rst      = 1'b0;
      div_load = 1'b0;
      en       = 1'b1;
      run(10);

      // reset mid-period with a pending divisor
      load_step(9);
      load_step(7);
      check("busy_before_rst", int'(busy), 1);
      rst = 1'b1;
      step();
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_div_cur", int'(div_cur), DEF);
      check("rst_busy", int'(busy), 0);
      check("rst_div_err", int'(div_err), 0);
      rst = 1'b0;
      step();
      check("first_after_rst", int'(clk_out), 1);
      run(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of the divisor and internal counter; legal range is WIDTH >= 2.
REQ-002 Parameter DEFAULT_DIV, default 4, is the divisor in use after reset; legal range is 2 <= DEFAULT_DIV <= 2^WIDTH-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge only.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port en, input, 1 bit: count enable; when low, the divider holds.
REQ-006 Port div_val, input, WIDTH bits: the requested divisor N.
REQ-007 Port div_load, input, 1 bit: single-cycle strobe that requests div_val.
REQ-008 Port clk_out, output, 1 bit: registered divided clock.
REQ-009 Port tick, output, 1 bit: registered one-cycle pulse marking the last cycle of each output period.
REQ-010 Port div_cur, output, WIDTH bits: the divisor currently in use.
REQ-011 Port busy, output, 1 bit: high while an accepted divisor is pending.
REQ-012 Port div_err, output, 1 bit: one-cycle pulse that flags a rejected load.

Function
REQ-013 Internal state shall be: counter cnt (WIDTH bits), active divisor N (drives div_cur), pending divisor P, and pending flag (drives busy).
REQ-014 H shall be defined as ceil(N/2), computed at WIDTH+1 bits so that no overflow occurs at N = 2^WIDTH-1.
REQ-015 On each edge with en=1:
- clk_out <= (cnt < H);
- tick <= (cnt == N-1);
- cnt <= (cnt == N-1) ? 0 : cnt+1.
REQ-016 Each output period shall therefore be N clk cycles: clk_out high for H cycles and low for N-H cycles. Duty is exactly 50% for even N; for odd N the extra cycle goes to the high phase.
REQ-017 On each edge with en=0 and no pending divisor: cnt and clk_out shall hold their values, and tick shall be 0.
REQ-018 div_load with div_val >= 2 shall be accepted: P <= div_val and busy <= 1. A later accepted load overwrites P.
REQ-019 div_load with div_val < 2 shall be rejected: div_err <= 1 for exactly one cycle, and N, P and busy are unchanged. div_err shall be 0 on every other cycle.
REQ-020 A pending divisor shall be applied on the wrap edge (en=1 and cnt == N-1): N <= P, busy <= 0, cnt <= 0. The period in progress always completes with the old N, so there is no glitch or runt pulse.
REQ-021 With en=0 and busy=1, the pending divisor shall be applied on the next edge: N <= P, busy <= 0, cnt <= 0, clk_out <= 0.
REQ-022 If an accepted load occurs on the same edge that applies an earlier pending value:
- the earlier P is applied to N;
- the new div_val becomes P;
- busy stays 1.
REQ-023 If a load occurs on the same edge as an en=0 apply, the same precedence as REQ-022 shall hold.
REQ-024 div_cur shall change only on apply edges and on reset.
REQ-025 The block shall use a single clock domain, with no negedge logic and no combinational path from any input to any output.

Reset
REQ-026 While rst=1, on each edge, the block shall set cnt=0, N=DEFAULT_DIV, P=DEFAULT_DIV, busy=0, clk_out=0, tick=0 and div_err=0.
REQ-027 rst shall override en, div_load and any pending apply.
REQ-028 A reset in mid-period shall discard both the partial period and any pending divisor.
REQ-029 On the first edge with en=1 after rst deasserts, clk_out shall become 1.

Verification
REQ-030 Defaults scenario: rst for 2 cycles, then en=1 held.
- Required: clk_out = 1,1,0,0 repeating.
- Required: tick high on every 4th cycle, coincident with the second low cycle of clk_out.
- Required: div_cur = 4.
REQ-031 Load mid-period scenario: load div_val=5 at cnt=1.
- Required: busy high until the wrap edge, and the current 4-cycle period completes.
- Required: afterwards clk_out = 1,1,1,0,0 repeating and div_cur = 5.
REQ-032 Rejected load scenario: load div_val=1, then load div_val=0.
- Required: div_err pulses for one cycle each time.
- Required: div_cur, busy and the clk_out sequence are unaffected.
REQ-033 Enable scenario, part 1: drop en for 3 cycles mid-high-phase.
- Required: clk_out and cnt hold, tick=0, and the period resumes where it stopped.
REQ-034 Enable scenario, part 2: with en=0, load div_val=6.
- Required: the next edge gives div_cur = 6 and clk_out = 0.
- Required: after en is raised, clk_out = 1,1,1,0,0,0 repeating.
REQ-035 Boundary and reset scenario, WIDTH=8.
- Load 255: required clk_out high 128 cycles, low 127 cycles.
- Load 2 and 3 back-to-back: required that only 3 takes effect, at the wrap edge.
- Assert rst mid-period while busy=1: required that all outputs return to their reset values and div_cur = DEFAULT_DIV.
